x_dl_sweep_ctrl: RTL and testbench
==================================

Name: x_dl_sweep_ctrl

Overview:
- Measurement sequencer for the 32-bit delay line. Takes UART rx commands, fires a burst of N delay-line captures, and reduces each capture to a popcount (thermometer depth).
- Accumulates min, max and sum across the burst, then streams a 4-byte result to the UART tx through a valid/accept handshake.
- Sits between the UART rx/tx blocks and the delay line, in place of a single-shot driver.

Parameters:
- p_settle, 4: cycles from the o_start pulse to sampling i_dl (range 1..255).
- p_gap, 2: idle cycles between captures in a burst (range 0..255).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  rx byte strobe, 1 cycle
- i_data  input  8  rx byte
- o_valid  output  1  tx byte valid
- i_accept  input  1  tx accepts byte
- o_data  output  8  tx byte
- o_start  output  1  delay-line launch pulse
- i_dl  input  32  delay-line capture
- o_busy  output  1  burst or result transmission in progress

Behaviour:
- Reset: one clock, i_clk; reset asynchronous active-low on i_rst_n.
  - Outputs: o_valid=0, o_data=0x00, o_start=0, o_busy=0.
  - State: IDLE, count register=1, accumulators cleared.
- Commands, accepted only in IDLE when i_valid=1:
  - i_data[7]=1: count = i_data[6:0], where 0 means 128. Stay in IDLE. No tx response.
  - i_data==0x47 ('G'): start a burst. Next state LAUNCH. On the same edge: min=63, max=0, sum=0, sample index=0.
  - Any other byte: ignored.
  - Any rx byte outside IDLE is dropped and has no effect.
- State LAUNCH: o_start=1 for exactly this one cycle, then SETTLE.
- State SETTLE: wait p_settle cycles counted from the LAUNCH cycle, then SAMPLE.
  - i_dl is sampled exactly p_settle cycles after the LAUNCH cycle.
- State SAMPLE, 1 cycle:
  - pc = popcount(i_dl), 6 bits, range 0..32.
  - min = min(min, pc); max = max(max, pc); sum += pc, 16-bit, cannot overflow (max 4096).
  - index += 1. If index == count, go to SEND0; else go to GAP.
- State GAP: p_gap cycles (skipped when p_gap=0), then LAUNCH.
- SEND0..SEND3 transmit, in order:
  - {2'b0,min}
  - {2'b0,max}
  - sum[15:8]
  - sum[7:0]
- Tx handshake:
  - o_valid is asserted with o_data stable until a cycle where o_valid & i_accept.
  - The next byte is presented on the following cycle; o_valid stays high between bytes.
  - o_valid and o_data must not change while not accepted.
  - After the 4th accept: o_valid=0 next cycle, return to IDLE.
- o_busy=1 in every state except IDLE.
- o_start is never asserted outside LAUNCH. At most one o_start per capture.
- Latency, p_settle=4, p_gap=2, count=1:
  - 'G' at cycle t, LAUNCH at t+1, SAMPLE at t+5.
  - First byte valid at t+6.
- Per-capture period: 1 + p_settle + p_gap cycles (LAUNCH + settle + gap); the SAMPLE cycle overlaps the last settle count.
- Count changes take effect only at the next 'G'. A burst uses the count latched at 'G'.
- i_accept while o_valid=0: ignored.
- Reset asserted mid-burst or mid-send:
  - Immediate return to IDLE, outputs to reset values.
  - Partial result is discarded; count returns to 1.

Test Plan:
- Reset, then 'G' with i_dl=0x0000FFFF held, accept tied 1 -> one o_start pulse. Bytes 0x10, 0x10, 0x00, 0x10.
- Send 0x83, then 'G'; i_dl returns 0x00000001, 0x000000FF, 0xFFFFFFFF on successive samples -> 3 o_start pulses spaced 1+p_settle+p_gap cycles apart. Bytes 0x01, 0x20, 0x00, 0x29.
- Send 0x80 (count 128), 'G', i_dl=0xFFFFFFFF -> 128 starts. Bytes 0x20, 0x20, 0x10, 0x00.
- Tx backpressure: i_accept low 10 cycles on each byte -> o_data/o_valid held stable. Exactly 4 bytes in order, no duplication.
- Extra rx bytes: send 'G' and 0x85 during a burst -> both dropped. Count stays at the previous value, no second burst. Byte 0x41 in IDLE -> no response.
- Deassert i_rst_n during SEND1 -> o_valid=0 and o_busy=0 asynchronously. Subsequent 'G' runs count=1.

Source files
------------

// File: rtl/x_dl_sweep_ctrl.sv
// x_dl_sweep_ctrl: burst measurement sequencer for the 32-bit delay line.
// Takes rx commands, fires N captures, reduces each capture to a popcount,
// and keeps the min, max and sum of those popcounts. The result goes out as
// four tx bytes.
// Tx handshake: o_valid rises with o_data already stable. Both hold until a
// cycle with o_valid & i_accept. The next byte appears on the following
// cycle, and i_accept is ignored while o_valid is low.
module x_dl_sweep_ctrl #(
  parameter int unsigned p_settle = 4,
  parameter int unsigned p_gap    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  input  logic        i_accept,
  output logic [7:0]  o_data,
  output logic        o_start,
  input  logic [31:0] i_dl,
  output logic        o_busy
);

  typedef enum logic [3:0] {
    IDLE, LAUNCH, SETTLE, SAMPLE, GAP, SEND0, SEND1, SEND2, SEND3
  } state_t;

  // SETTLE ends one count early because the SAMPLE cycle itself is the last settle cycle.
  localparam logic [7:0] settle_last = 8'(p_settle - 1);
  localparam logic [7:0] gap_last    = 8'(p_gap);
  localparam logic [7:0] cmd_go      = 8'h47;

  state_t      state;
  logic [7:0]  count;
  logic [7:0]  burst_count;
  logic [7:0]  index;
  logic [7:0]  timer;
  logic [5:0]  min_pc;
  logic [5:0]  max_pc;
  logic [15:0] sum_pc;

  logic [5:0]  pc;
  logic [5:0]  next_min;
  logic [5:0]  next_max;
  logic [15:0] next_sum;
  logic [7:0]  next_index;

  // Popcount of the capture and the accumulator values after folding it in.
  always_comb begin
    pc = 6'd0;
    for (int i = 0; i < 32; i++) begin
      pc = pc + 6'(i_dl[i]);
    end
    next_min   = (pc < min_pc) ? pc : min_pc;
    next_max   = (pc > max_pc) ? pc : max_pc;
    next_sum   = sum_pc + 16'(pc);
    next_index = index + 8'd1;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      count       <= 8'd1;
      burst_count <= 8'd1;
      index       <= 8'd0;
      timer       <= 8'd0;
      min_pc      <= 6'd0;
      max_pc      <= 6'd0;
      sum_pc      <= 16'd0;
      o_valid     <= 1'b0;
      o_data      <= 8'h00;
      o_start     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (i_data[7]) begin
              count <= (i_data[6:0] == 7'd0) ? 8'd128 : {1'b0, i_data[6:0]};
            end else if (i_data == cmd_go) begin
              state       <= LAUNCH;
              o_start     <= 1'b1;
              o_busy      <= 1'b1;
              burst_count <= count;
              min_pc      <= 6'd63;
              max_pc      <= 6'd0;
              sum_pc      <= 16'd0;
              index       <= 8'd0;
            end
          end
        end
        LAUNCH: begin
          o_start <= 1'b0;
          timer   <= 8'd1;
          state   <= (p_settle == 1) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          if (timer == settle_last) begin
            state <= SAMPLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        SAMPLE: begin
          min_pc <= next_min;
          max_pc <= next_max;
          sum_pc <= next_sum;
          index  <= next_index;
          if (next_index == burst_count) begin
            state   <= SEND0;
            o_valid <= 1'b1;
            o_data  <= {2'b00, next_min};
          end else if (p_gap == 0) begin
            state   <= LAUNCH;
            o_start <= 1'b1;
          end else begin
            state <= GAP;
            timer <= 8'd1;
          end
        end
        GAP: begin
          if (timer == gap_last) begin
            state   <= LAUNCH;
            o_start <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        SEND0: begin
          if (i_accept) begin
            state  <= SEND1;
            o_data <= {2'b00, max_pc};
          end
        end
        SEND1: begin
          if (i_accept) begin
            state  <= SEND2;
            o_data <= sum_pc[15:8];
          end
        end
        SEND2: begin
          if (i_accept) begin
            state  <= SEND3;
            o_data <= sum_pc[7:0];
          end
        end
        SEND3: begin
          if (i_accept) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_data  <= 8'h00;
            o_busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_dl_sweep_ctrl.sv
// Bench for x_dl_sweep_ctrl with the default parameters (settle 4, gap 2).
module tb_x_dl_sweep_ctrl;

  localparam int period = 7;   // 1 + settle + gap
  localparam int lat    = 5;   // last o_start to first o_valid
  localparam int limit  = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_valid;
  logic        i_accept;
  logic [7:0]  o_data;
  logic        o_start;
  logic [31:0] i_dl;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  int          starts[$];
  int          cyc = 0;
  int          valid_rise = -1;
  logic [31:0] pat[3];
  int          k = 0;
  int          acc_mode = 0;
  int          w = 0;
  logic        prev_v = 1'b0;
  logic        prev_a = 1'b0;
  logic [7:0]  prev_d = 8'h00;

  typedef struct {
    logic [7:0]  cnt_cmd;
    int          n;
    logic [31:0] dl[3];
    logic [7:0]  exp[4];
    int          bp;
  } vec_t;
  vec_t vecs[4];

  x_dl_sweep_ctrl #(.p_settle(4), .p_gap(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .i_accept(i_accept), .o_data(o_data),
    .o_start(o_start), .i_dl(i_dl), .o_busy(o_busy)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drivers: capture data follows each o_start; accept follows acc_mode.
  always @(posedge clk) begin
    #1;
    if (o_start === 1'b1) begin
      i_dl = pat[k % 3];
      k++;
    end
    if (acc_mode == 0) begin
      i_accept = 1'b1;
    end else if (acc_mode == 1) begin
      if (o_valid !== 1'b1) begin
        i_accept = 1'b0;
        w = 0;
      end else if (w == 10) begin
        i_accept = 1'b1;
        w = 0;
      end else begin
        i_accept = 1'b0;
        w++;
      end
    end
  end

  // Monitor: start times, tx stability and scoreboard pops.
  always @(negedge clk) begin
    if (o_start === 1'b1) starts.push_back(cyc);
    if (o_valid === 1'b1 && prev_v !== 1'b1) valid_rise = cyc;
    if (rst_n && prev_v === 1'b1 && prev_a !== 1'b1) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_data", 32'(o_data), 32'(prev_d));
    end
    if (o_valid === 1'b1 && i_accept === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(o_data), 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
    prev_v = o_valid;
    prev_d = o_data;
    prev_a = i_accept;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_data  = 8'h00;
  endtask

  task automatic wait_busy(input logic lvl);
    for (int i = 0; i < limit && o_busy !== lvl; i++) @(posedge clk);
    #1;
    chk("busy_wait", 32'(o_busy), 32'(lvl));
  endtask

  task automatic run_burst(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input bit extra);
    int g;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    starts.delete();
    k = 0;
    valid_rise = -1;
    send_byte(8'h47);
    g = cyc;
    if (extra) begin
      send_byte(8'h47);
      send_byte(8'h85);
    end
    wait_busy(1'b1);
    wait_busy(1'b0);
    repeat (2) @(posedge clk);
    chk("start_count", 32'(starts.size()), 32'(n));
    if (starts.size() > 0) begin
      chk("first_start", 32'(starts[0]), 32'(g));
      chk("first_valid", 32'(valid_rise), 32'(starts[starts.size()-1] + lat));
      for (int i = 1; i < starts.size(); i++)
        chk("start_spacing", 32'(starts[i] - starts[i-1]), 32'(period));
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_accept = 1'b1; i_dl = 32'h0;
    pat[0] = 32'h0; pat[1] = 32'h0; pat[2] = 32'h0;

    vecs[0] = '{8'h00, 1,   '{32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF}, '{8'h10, 8'h10, 8'h00, 8'h10}, 0};
    vecs[1] = '{8'h83, 3,   '{32'h00000001, 32'h000000FF, 32'hFFFFFFFF}, '{8'h01, 8'h20, 8'h00, 8'h29}, 0};
    vecs[2] = '{8'h80, 128, '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, '{8'h20, 8'h20, 8'h10, 8'h00}, 0};
    vecs[3] = '{8'h82, 2,   '{32'h00000000, 32'h80000001, 32'h00000000}, '{8'h00, 8'h02, 8'h00, 8'h02}, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_start", 32'(o_start), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven bursts.
    for (int v = 0; v < 4; v++) begin
      acc_mode = vecs[v].bp;
      for (int j = 0; j < 3; j++) pat[j] = vecs[v].dl[j];
      if (vecs[v].cnt_cmd != 8'h00) send_byte(vecs[v].cnt_cmd);
      run_burst(vecs[v].n, vecs[v].exp[0], vecs[v].exp[1], vecs[v].exp[2], vecs[v].exp[3], 1'b0);
    end
    acc_mode = 0;

    // Rx bytes during a burst are dropped (count stays 2).
    for (int j = 0; j < 3; j++) pat[j] = 32'h0000000F;
    run_burst(2, 8'h04, 8'h04, 8'h00, 8'h08, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("no_second_burst", 32'(starts.size()), 32'd2);
    chk("idle_after_drop", 32'(o_busy), 32'd0);

    // Unknown byte in IDLE gives no response.
    begin
      bit seen;
      seen = 1'b0;
      send_byte(8'h41);
      repeat (20) begin
        @(negedge clk);
        seen = seen | o_busy | o_valid | o_start;
      end
      chk("ignore_0x41", 32'(seen), 32'd0);
    end

    // Count unchanged by the dropped 0x85.
    for (int j = 0; j < 3; j++) pat[j] = 32'h00000001;
    run_burst(2, 8'h01, 8'h01, 8'h00, 8'h02, 1'b0);

    // Reset during SEND1.
    acc_mode = 2;
    i_accept = 1'b0;
    for (int j = 0; j < 3; j++) pat[j] = 32'h00000003;
    exp_q.push_back(8'h02);
    send_byte(8'h47);
    for (int i = 0; i < limit && o_valid !== 1'b1; i++) @(posedge clk);
    chk("send0_reached", 32'(o_valid), 32'd1);
    @(posedge clk); #1;
    i_accept = 1'b1;
    @(posedge clk); #1;
    i_accept = 1'b0;
    chk("send1_data", 32'(o_data), 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_data", 32'(o_data), 32'd0);
    chk("arst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_mode = 0;
    for (int j = 0; j < 3; j++) pat[j] = 32'h0000000F;
    run_burst(1, 8'h04, 8'h04, 8'h00, 8'h04, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
